qspi_psram_responder: RTL and testbench

QSPI_PSRAM_RESPONDER -- requirements
Module: qspi_psram_responder

---
 rtl/qspi_pkg.sv | 27 ++
 rtl/qspi_pin_sync.sv | 47 ++++
 rtl/qspi_psram_responder.sv | 169 ++++++++++++++++
 tb/tb_qspi_psram_responder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
//============================================================================
// Module   : qspi_pkg
// Brief    : Shared opcodes, address width and FSM states for the QSPI PSRAM responder
// Revision : 1.0
//============================================================================
`default_nettype none

package qspi_pkg;

  localparam int          c_ADDR_W    = 24;
  localparam int          c_ADDR_NIBS = c_ADDR_W / 4;
  localparam logic [7:0]  c_READ_OP   = 8'hEB;
  localparam logic [7:0]  c_WRITE_OP  = 8'h38;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RDATA  = 3'd4,
    ST_WDATA  = 3'd5,
    ST_IGNORE = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/qspi_pin_sync.sv
//============================================================================
// Module   : qspi_pin_sync
// Brief    : Two-flop synchronizers for cs_n/sclk/io plus one-clk sclk edge pulses
// Revision : 1.0
//============================================================================
`default_nettype none

module qspi_pin_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_cs_n,
  input  logic       i_sclk,
  input  logic [3:0] i_io_in,
  output logic       o_cs_n,
  output logic [3:0] o_io,
  output logic       o_sclk_rise,
  output logic       o_sclk_fall
);

  logic [1:0] r_cs_q;
  logic [2:0] r_sclk_q;
  logic [3:0] r_io_q1;
  logic [3:0] r_io_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cs_q   <= 2'b11;
      r_sclk_q <= 3'b000;
      r_io_q1  <= 4'h0;
      r_io_q2  <= 4'h0;
    end else begin
      r_cs_q   <= {r_cs_q[0], i_cs_n};
      r_sclk_q <= {r_sclk_q[1:0], i_sclk};
      r_io_q1  <= i_io_in;
      r_io_q2  <= r_io_q1;
    end
  end

  // io uses the same depth as sclk so a rise pulse sees the data the master set up
  assign o_cs_n      = r_cs_q[1];
  assign o_io        = r_io_q2;
  assign o_sclk_rise = r_sclk_q[1] & ~r_sclk_q[2];
  assign o_sclk_fall = ~r_sclk_q[1] & r_sclk_q[2];

endmodule

`default_nettype wire

// File: rtl/qspi_psram_responder.sv
//============================================================================
// Module   : qspi_psram_responder
// Brief    : Quad-SPI PSRAM-style slave with quad read/write into an internal byte RAM
// Revision : 1.0
//============================================================================
`default_nettype none

module qspi_psram_responder
  import qspi_pkg::*;
#(
  parameter int         MEM_BYTES   = 256,
  parameter int         WAIT_CYCLES = 6,
  parameter logic [7:0] READ_OP     = c_READ_OP,
  parameter logic [7:0] WRITE_OP    = c_WRITE_OP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_n,
  input  logic       sclk,
  input  logic [3:0] io_in,
  output logic [3:0] io_out,
  output logic [3:0] io_oe,
  output logic       busy
);

  localparam int                IDX_W       = $clog2(MEM_BYTES);
  localparam int                WAIT_W      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [2:0]        c_ADDR_LAST = 3'(c_ADDR_NIBS - 1);

  logic        w_cs_n;
  logic [3:0]  w_io;
  logic        w_rise;
  logic        w_fall;
  logic [7:0]  w_op;
  state_t      r_state;
  state_t      w_next;

  logic [1:0]        r_flush;
  logic              r_cs_d;
  logic [2:0]        r_cnt;
  logic [WAIT_W-1:0] r_wait;
  logic [3:0]        r_op_hi;
  logic              r_is_read;
  logic [IDX_W-1:0]  r_idx;
  logic [7:0]        r_wbyte;
  logic              r_we;
  logic [3:0]        r_io_out;
  logic [7:0]        r_rd_data;
  logic [7:0]        r_mem [MEM_BYTES];

  qspi_pin_sync u_pin_sync (
    .clk         (clk),
    .rst         (rst),
    .i_cs_n      (cs_n),
    .i_sclk      (sclk),
    .i_io_in     (io_in),
    .o_cs_n      (w_cs_n),
    .o_io        (w_io),
    .o_sclk_rise (w_rise),
    .o_sclk_fall (w_fall)
  );

  assign w_op = {r_op_hi, w_io};

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // r_cs_d is only set by a genuine high after reset, so a cs_n held low through rst never restarts
  always_comb begin
    w_next = r_state;
    if (w_cs_n) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (r_cs_d) w_next = ST_CMD;
        ST_CMD:   if (w_rise && r_cnt[0])
                    w_next = (w_op == READ_OP || w_op == WRITE_OP) ? ST_ADDR : ST_IGNORE;
        ST_ADDR:  if (w_rise && r_cnt == c_ADDR_LAST) begin
                    if (!r_is_read)            w_next = ST_WDATA;
                    else if (WAIT_CYCLES == 0) w_next = ST_RDATA;
                    else                       w_next = ST_WAIT;
                  end
        ST_WAIT:  if (w_rise && r_wait == c_WAIT_LAST) w_next = ST_RDATA;
        default:  w_next = r_state;
      endcase
    end
  end

  always_comb begin
    io_out = r_io_out;
    io_oe  = 4'h0;
    busy   = 1'b0;
    if (r_state == ST_RDATA) io_oe = 4'hF;
    if (r_state != ST_IDLE)  busy  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush   <= 2'd0;
      r_cs_d    <= 1'b0;
      r_cnt     <= 3'd0;
      r_wait    <= '0;
      r_op_hi   <= 4'h0;
      r_is_read <= 1'b0;
      r_idx     <= '0;
      r_wbyte   <= 8'h00;
      r_we      <= 1'b0;
      r_io_out  <= 4'h0;
    end else begin
      r_flush <= (r_flush == 2'd2) ? r_flush : r_flush + 2'd1;
      r_cs_d  <= w_cs_n && (r_flush == 2'd2);
      r_we    <= 1'b0;
      if (r_we) r_idx <= r_idx + IDX_W'(1);
      if (r_state != ST_RDATA) r_io_out <= 4'h0;

      if (!w_cs_n && w_rise) begin
        case (r_state)
          ST_CMD: begin
            r_op_hi   <= w_io;
            r_is_read <= (w_op == READ_OP);
            r_cnt     <= r_cnt + 3'd1;
          end
          ST_ADDR: begin
            r_idx <= IDX_W'({r_idx, w_io});
            r_cnt <= r_cnt + 3'd1;
          end
          ST_WAIT: r_wait <= r_wait + WAIT_W'(1);
          ST_WDATA: begin
            if (!r_cnt[0]) begin
              r_wbyte[7:4] <= w_io;
            end else begin
              r_wbyte[3:0] <= w_io;
              r_we         <= 1'b1;
            end
            r_cnt <= {2'b00, ~r_cnt[0]};
          end
          default: ;
        endcase
      end

      if (!w_cs_n && w_fall && r_state == ST_RDATA) begin
        if (!r_cnt[0]) begin
          r_io_out <= r_rd_data[7:4];
        end else begin
          r_io_out <= r_rd_data[3:0];
          r_idx    <= r_idx + IDX_W'(1);
        end
        r_cnt <= {2'b00, ~r_cnt[0]};
      end

      if (w_next != r_state) begin
        r_cnt  <= 3'd0;
        r_wait <= '0;
      end
    end
  end

  // Single-port, read-first RAM; contents deliberately survive rst
  always_ff @(posedge clk) begin
    if (r_we) r_mem[r_idx] <= r_wbyte;
    r_rd_data <= r_mem[r_idx];
  end

endmodule

`default_nettype wire

// File: tb/tb_qspi_psram_responder.sv
//============================================================================
// Module   : tb_qspi_psram_responder
// Brief    : Directed quad-SPI master driving the PSRAM responder
// Revision : 1.0
//============================================================================
`default_nettype none

module tb_qspi_psram_responder;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs_n;
  logic       sclk;
  logic [3:0] io_in;
  logic [3:0] io_out;
  logic [3:0] io_oe;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  qspi_psram_responder #(
    .MEM_BYTES   (256),
    .WAIT_CYCLES (6),
    .READ_OP     (8'hEB),
    .WRITE_OP    (8'h38)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .cs_n   (cs_n),
    .sclk   (sclk),
    .io_in  (io_in),
    .io_out (io_out),
    .io_oe  (io_oe),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_nib(input logic [3:0] n);
    io_in = n;
    wait_clk(HALF);
    sclk = 1'b1;
    wait_clk(HALF);
    sclk = 1'b0;
  endtask

  task automatic tx_byte(input logic [7:0] b);
    tx_nib(b[7:4]);
    tx_nib(b[3:0]);
  endtask

  task automatic tx_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) tx_nib(a[i*4 +: 4]);
  endtask

  task automatic cs_start();
    cs_n = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_end();
    wait_clk(2);
    cs_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic dummy(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      io_in = 4'h0;
      wait_clk(HALF);
      check({tag, "_dummy_oe"}, io_oe, 4'h0);
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic rx_nib(input string tag, input logic [3:0] exp);
    wait_clk(HALF);
    check({tag, "_oe"}, io_oe, 4'hF);
    check(tag, io_out, exp);
    sclk = 1'b1;
    wait_clk(HALF);
    sclk = 1'b0;
  endtask

  task automatic write_bytes(input logic [23:0] a, input logic [15:0] d, input int n);
    cs_start();
    tx_byte(8'h38);
    tx_addr(a);
    for (int i = 0; i < n; i++) tx_byte(d[15-8*i -: 8]);
    cs_end();
  endtask

  task automatic read_check(input string tag, input logic [23:0] a, input logic [15:0] d, input int n);
    cs_start();
    tx_byte(8'hEB);
    tx_addr(a);
    dummy(tag, 6);
    for (int i = 0; i < n; i++) begin
      rx_nib(tag, d[15-8*i -: 4]);
      rx_nib(tag, d[11-8*i -: 4]);
    end
    cs_end();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] pat;
    rst   = 1'b1;
    cs_n  = 1'b1;
    sclk  = 1'b0;
    io_in = 4'h0;
    wait_clk(3);
    check("rst_oe", io_oe, 4'h0);
    check("rst_out", io_out, 4'h0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    wait_clk(4);

    // Basic write then read back
    cs_start();
    check("wr_busy", busy, 1'b1);
    tx_byte(8'h38);
    tx_addr(24'h000010);
    tx_byte(8'hA5);
    check("wr_oe", io_oe, 4'h0);
    tx_byte(8'h3C);
    cs_end();
    check("wr_idle", busy, 1'b0);
    read_check("rd10", 24'h000010, 16'hA53C, 2);
    check("rd10_end_oe", io_oe, 4'h0);

    // Index wrap at the top of memory
    write_bytes(24'h0000FF, 16'h1122, 2);
    read_check("wrap00", 24'h000000, 16'h2200, 1);
    read_check("wrapFF", 24'h0000FF, 16'h1122, 2);

    // Unknown opcode: pattern would be a write of FF at 0x40 if misdecoded
    write_bytes(24'h000040, 16'h5A00, 1);
    pat = 64'h000040FF_FFFFFFFF;
    cs_start();
    tx_byte(8'h9F);
    for (int i = 0; i < 16; i++) begin
      tx_nib(pat[63-4*i -: 4]);
      check("ign_oe", io_oe, 4'h0);
    end
    check("ign_busy", busy, 1'b1);
    cs_end();
    check("ign_idle", busy, 1'b0);
    read_check("ign40", 24'h000040, 16'h5A00, 1);

    // Partial trailing byte is dropped
    write_bytes(24'h000020, 16'h9600, 1);
    cs_start();
    tx_byte(8'h38);
    tx_addr(24'h000020);
    tx_nib(4'h7);
    cs_end();
    read_check("part20", 24'h000020, 16'h9600, 1);

    // Reset during read data
    cs_start();
    tx_byte(8'hEB);
    tx_addr(24'h000010);
    dummy("rstrd", 6);
    rx_nib("rst_pre", 4'hA);
    wait_clk(4);
    rst = 1'b1;
    wait_clk(1);
    check("rst_mid_oe", io_oe, 4'h0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_out", io_out, 4'h0);
    rst = 1'b0;
    wait_clk(10);
    check("rst_hold_busy", busy, 1'b0);
    cs_n = 1'b1;
    wait_clk(8);
    read_check("rst_rd", 24'h000010, 16'hA53C, 2);

    // Upper address bits alias onto the same index
    write_bytes(24'h123405, 16'hC300, 1);
    read_check("alias05", 24'h000005, 16'hC300, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
